// File: rtl/regfile_dual_pkg.sv
// Shared constants and bus-geometry helpers for the dual-issue register file.
// Writeback bus layout, LSB first:
//   lane i1 = {hilo_i1, we_i1, waddr_i1, wdata_i1}
//   lane i2 = {hilo_i2, we_i2, waddr_i2, wdata_i2}, packed above lane i1
//   hilo    = {hi_we, lo_we, hi, lo}
package regfile_dual_pkg;

    localparam int unsigned RegAddrW = 5;
    localparam int unsigned NumRegs  = 32;

    // Width of one HI/LO write lane: two enables plus both halves.
    function automatic int unsigned hilo_wd(input int unsigned dw);
        return 2 * dw + 2;
    endfunction

    // Width of one writeback lane (GPR write fields plus HI/LO lane).
    function automatic int unsigned lane_wd(input int unsigned dw);
        return hilo_wd(dw) + 1 + RegAddrW + dw;
    endfunction

    // Full writeback bus: two lanes.
    function automatic int unsigned wb_to_rf_wd(input int unsigned dw);
        return 2 * lane_wd(dw);
    endfunction

    // Field offsets inside one lane.
    function automatic int unsigned waddr_off(input int unsigned dw);
        return dw;
    endfunction

    function automatic int unsigned we_off(input int unsigned dw);
        return dw + RegAddrW;
    endfunction

    function automatic int unsigned hilo_off(input int unsigned dw);
        return dw + RegAddrW + 1;
    endfunction

endpackage

// File: rtl/regfile_dual_hilo_reg.sv
// HI/LO storage for the dual-issue core.
// Two write lanes with independent per-half enables; lane i2 (younger) wins a
// conflict on the same half. Reads optionally bypass the same-cycle write.
// Ports:
//   clk, resetn        clock and asynchronous active-low reset
//   hilo1_i, hilo2_i   HI/LO write lanes {hi_we, lo_we, hi, lo} (i1 older)
//   hi_rdata_o         HI read value, combinational
//   lo_rdata_o         LO read value, combinational
module regfile_dual_hilo_reg
    import regfile_dual_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter bit          BYPASS_EN = 1'b1
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [hilo_wd(DATA_W)-1:0]  hilo1_i,
    input  logic [hilo_wd(DATA_W)-1:0]  hilo2_i,
    output logic [DATA_W-1:0]           hi_rdata_o,
    output logic [DATA_W-1:0]           lo_rdata_o
);

    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;

    logic              hi_we1, lo_we1, hi_we2, lo_we2;
    logic [DATA_W-1:0] hi1, lo1, hi2, lo2;

    assign lo1    = hilo1_i[DATA_W-1:0];
    assign hi1    = hilo1_i[2*DATA_W-1:DATA_W];
    assign lo_we1 = hilo1_i[2*DATA_W];
    assign hi_we1 = hilo1_i[2*DATA_W+1];

    assign lo2    = hilo2_i[DATA_W-1:0];
    assign hi2    = hilo2_i[2*DATA_W-1:DATA_W];
    assign lo_we2 = hilo2_i[2*DATA_W];
    assign hi_we2 = hilo2_i[2*DATA_W+1];

    // Lane i2 is applied last so it overrides i1 on the same half.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (hi_we1) hi_d = hi1;
        if (lo_we1) lo_d = lo1;
        if (hi_we2) hi_d = hi2;
        if (lo_we2) lo_d = lo2;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // Next-state already carries the arbitrated write, so it doubles as the
    // bypass value. Reset forces zero even while a write is on the bus.
    always_comb begin
        hi_rdata_o = '0;
        lo_rdata_o = '0;
        if (resetn) begin
            hi_rdata_o = BYPASS_EN ? hi_d : hi_q;
            lo_rdata_o = BYPASS_EN ? lo_d : lo_q;
        end
    end

endmodule

// File: rtl/regfile_dual.sv
// Architectural register state for the dual-issue core: 31 GPRs ($0 reads
// zero) plus HI/LO, written from the writeback bus and read by decode.
// Ports:
//   clk, resetn        clock and asynchronous active-low reset
//   wb_to_rf_bus       two writeback lanes (i2 in the upper half, i1 lower)
//   raddr1..raddr4     read addresses (1/2 = i1 rs/rt, 3/4 = i2 rs/rt)
//   rdata1..rdata4     read data, combinational
//   hi_rdata, lo_rdata HI/LO read data, combinational
module regfile_dual
    import regfile_dual_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter bit          BYPASS_EN = 1'b1
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [wb_to_rf_wd(DATA_W)-1:0]  wb_to_rf_bus,
    input  logic [RegAddrW-1:0]             raddr1,
    input  logic [RegAddrW-1:0]             raddr2,
    input  logic [RegAddrW-1:0]             raddr3,
    input  logic [RegAddrW-1:0]             raddr4,
    output logic [DATA_W-1:0]               rdata1,
    output logic [DATA_W-1:0]               rdata2,
    output logic [DATA_W-1:0]               rdata3,
    output logic [DATA_W-1:0]               rdata4,
    output logic [DATA_W-1:0]               hi_rdata,
    output logic [DATA_W-1:0]               lo_rdata
);

    localparam int unsigned LaneW = lane_wd(DATA_W);
    localparam int unsigned HiloW = hilo_wd(DATA_W);

    logic [LaneW-1:0]    lane1, lane2;
    logic [DATA_W-1:0]   wdata1, wdata2;
    logic [RegAddrW-1:0] waddr1, waddr2;
    logic                we1, we2;
    logic [HiloW-1:0]    hilo1, hilo2;

    assign lane1  = wb_to_rf_bus[LaneW-1:0];
    assign lane2  = wb_to_rf_bus[2*LaneW-1:LaneW];

    assign wdata1 = lane1[DATA_W-1:0];
    assign waddr1 = lane1[waddr_off(DATA_W) +: RegAddrW];
    assign we1    = lane1[we_off(DATA_W)];
    assign hilo1  = lane1[hilo_off(DATA_W) +: HiloW];

    assign wdata2 = lane2[DATA_W-1:0];
    assign waddr2 = lane2[waddr_off(DATA_W) +: RegAddrW];
    assign we2    = lane2[we_off(DATA_W)];
    assign hilo2  = lane2[hilo_off(DATA_W) +: HiloW];

    // Entry 0 is held at zero; it is never written and optimises away.
    logic [DATA_W-1:0] gpr_q [NumRegs];
    logic [DATA_W-1:0] gpr_d [NumRegs];

    // Lane i2 is applied last so the younger instruction wins a same-address
    // conflict; $0 is re-zeroed after both lanes to drop writes to it.
    always_comb begin
        gpr_d = gpr_q;
        if (we1) gpr_d[waddr1] = wdata1;
        if (we2) gpr_d[waddr2] = wdata2;
        gpr_d[0] = '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NumRegs; i++) begin
                gpr_q[i] <= '0;
            end
        end else begin
            gpr_q <= gpr_d;
        end
    end

    logic [RegAddrW-1:0] raddr [4];
    logic [DATA_W-1:0]   rdata [4];

    assign raddr[0] = raddr1;
    assign raddr[1] = raddr2;
    assign raddr[2] = raddr3;
    assign raddr[3] = raddr4;

    // Bypass reads the arbitrated next state, which already encodes the
    // i2-over-i1 priority and the $0 drop.
    always_comb begin
        for (int p = 0; p < 4; p++) begin
            rdata[p] = '0;
            if (resetn && (raddr[p] != '0)) begin
                rdata[p] = BYPASS_EN ? gpr_d[raddr[p]] : gpr_q[raddr[p]];
            end
        end
    end

    assign rdata1 = rdata[0];
    assign rdata2 = rdata[1];
    assign rdata3 = rdata[2];
    assign rdata4 = rdata[3];

    regfile_dual_hilo_reg #(
        .DATA_W    (DATA_W),
        .BYPASS_EN (BYPASS_EN)
    ) u_hilo_reg (
        .clk        (clk),
        .resetn     (resetn),
        .hilo1_i    (hilo1),
        .hilo2_i    (hilo2),
        .hi_rdata_o (hi_rdata),
        .lo_rdata_o (lo_rdata)
    );

endmodule

// File: tb/tb_regfile_dual.sv
// Scoreboard bench for regfile_dual. One instance with bypass and one without
// share the same stimulus. The driver computes expected reads from an
// array-based model and queues them; a monitor on the falling edge compares.
module tb_regfile_dual;

    localparam int W  = 32;
    localparam int BW = 208;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [BW-1:0] bus = '0;
    logic [4:0]    ra [4];
    logic [W-1:0]  rd_b [4];
    logic [W-1:0]  rd_n [4];
    logic [W-1:0]  hi_b, lo_b, hi_n, lo_n;

    always #5 clk = ~clk;

    regfile_dual #(
        .DATA_W    (W),
        .BYPASS_EN (1'b1)
    ) u_dut_byp (
        .clk          (clk),
        .resetn       (resetn),
        .wb_to_rf_bus (bus),
        .raddr1       (ra[0]),
        .raddr2       (ra[1]),
        .raddr3       (ra[2]),
        .raddr4       (ra[3]),
        .rdata1       (rd_b[0]),
        .rdata2       (rd_b[1]),
        .rdata3       (rd_b[2]),
        .rdata4       (rd_b[3]),
        .hi_rdata     (hi_b),
        .lo_rdata     (lo_b)
    );

    regfile_dual #(
        .DATA_W    (W),
        .BYPASS_EN (1'b0)
    ) u_dut_nobyp (
        .clk          (clk),
        .resetn       (resetn),
        .wb_to_rf_bus (bus),
        .raddr1       (ra[0]),
        .raddr2       (ra[1]),
        .raddr3       (ra[2]),
        .raddr4       (ra[3]),
        .rdata1       (rd_n[0]),
        .rdata2       (rd_n[1]),
        .rdata3       (rd_n[2]),
        .rdata4       (rd_n[3]),
        .hi_rdata     (hi_n),
        .lo_rdata     (lo_n)
    );

    // Reference model: architectural state after the last committed edge.
    logic [W-1:0] m_gpr [32];
    logic [W-1:0] m_hi, m_lo;

    // Per-cycle stimulus fields, index 0 = lane i1, 1 = lane i2.
    logic         t_we [2];
    logic [4:0]   t_a  [2];
    logic [W-1:0] t_d  [2];
    logic         t_hw [2];
    logic         t_lw [2];
    logic [W-1:0] t_h  [2];
    logic [W-1:0] t_l  [2];
    logic [4:0]   t_ra [4];

    typedef struct {
        int           id;
        logic [W-1:0] exp;
    } sb_t;

    sb_t sbq[$];
    int  n_checks = 0;
    int  n_err    = 0;

    function automatic string port_name(input int id);
        if (id < 4)   return $sformatf("rdata%0d_bypass", id + 1);
        if (id == 4)  return "hi_bypass";
        if (id == 5)  return "lo_bypass";
        if (id < 10)  return $sformatf("rdata%0d_nobypass", id - 5);
        if (id == 10) return "hi_nobypass";
        return "lo_nobypass";
    endfunction

    function automatic logic [W-1:0] actual(input int id);
        if (id < 4)   return rd_b[id];
        if (id == 4)  return hi_b;
        if (id == 5)  return lo_b;
        if (id < 10)  return rd_n[id-6];
        if (id == 10) return hi_n;
        return lo_n;
    endfunction

    // Monitor: everything queued for this cycle is compared mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            while (sbq.size() > 0) begin
                sb_t e;
                logic [W-1:0] a;
                e = sbq.pop_front();
                a = actual(e.id);
                n_checks++;
                if (a !== e.exp) begin
                    n_err++;
                    $display("FAIL %s actual=%h required=%h at %0t",
                             port_name(e.id), a, e.exp, $time);
                end
            end
        end
    end

    task automatic clr();
        for (int i = 0; i < 2; i++) begin
            t_we[i] = 1'b0; t_a[i] = '0; t_d[i] = '0;
            t_hw[i] = 1'b0; t_lw[i] = 1'b0; t_h[i] = '0; t_l[i] = '0;
        end
    endtask

    function automatic logic [4:0] rnd_addr();
        return ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
    endfunction

    task automatic rnd();
        for (int i = 0; i < 2; i++) begin
            t_we[i] = 1'($urandom);
            t_a[i]  = rnd_addr();
            t_d[i]  = $urandom;
            t_hw[i] = ($urandom_range(0, 3) == 0);
            t_lw[i] = ($urandom_range(0, 3) == 0);
            t_h[i]  = $urandom;
            t_l[i]  = $urandom;
        end
        for (int p = 0; p < 4; p++) begin
            t_ra[p] = ($urandom_range(0, 1) == 0) ? t_a[$urandom_range(0, 1)] : rnd_addr();
        end
    endtask

    // One cycle: present stimulus between edges, queue expectations, then
    // advance the model to the state the next rising edge should commit.
    task automatic drive(input bit rst);
        logic [W-1:0] nxt [32];
        logic [W-1:0] nhi, nlo;
        sb_t e;
        @(posedge clk);
        #1;
        resetn = !rst;
        bus = {t_hw[1], t_lw[1], t_h[1], t_l[1], t_we[1], t_a[1], t_d[1],
               t_hw[0], t_lw[0], t_h[0], t_l[0], t_we[0], t_a[0], t_d[0]};
        for (int p = 0; p < 4; p++) ra[p] = t_ra[p];
        if (rst) begin
            for (int r = 0; r < 32; r++) m_gpr[r] = '0;
            m_hi = '0;
            m_lo = '0;
        end
        nxt = m_gpr;
        for (int i = 0; i < 2; i++) begin
            if (t_we[i] && t_a[i] != 0) nxt[t_a[i]] = t_d[i];
        end
        nhi = m_hi;
        nlo = m_lo;
        for (int i = 0; i < 2; i++) begin
            if (t_hw[i]) nhi = t_h[i];
            if (t_lw[i]) nlo = t_l[i];
        end
        for (int p = 0; p < 4; p++) begin
            e.id = p;     e.exp = rst ? '0 : nxt[t_ra[p]];   sbq.push_back(e);
            e.id = p + 6; e.exp = rst ? '0 : m_gpr[t_ra[p]]; sbq.push_back(e);
        end
        e.id = 4;  e.exp = rst ? '0 : nhi;  sbq.push_back(e);
        e.id = 5;  e.exp = rst ? '0 : nlo;  sbq.push_back(e);
        e.id = 10; e.exp = rst ? '0 : m_hi; sbq.push_back(e);
        e.id = 11; e.exp = rst ? '0 : m_lo; sbq.push_back(e);
        if (!rst) begin
            m_gpr = nxt;
            m_hi  = nhi;
            m_lo  = nlo;
        end
    endtask

    task automatic set_ra(input logic [4:0] a);
        for (int p = 0; p < 4; p++) t_ra[p] = a;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) m_gpr[r] = '0;
        m_hi = '0;
        m_lo = '0;
        for (int p = 0; p < 4; p++) ra[p] = '0;
        clr();
        set_ra(5'd0);

        // Reset with random traffic on the bus: everything reads zero.
        rnd();
        drive(1'b1);
        rnd();
        drive(1'b1);

        // Release, then read all 32 addresses.
        clr();
        for (int k = 0; k < 8; k++) begin
            for (int p = 0; p < 4; p++) t_ra[p] = 5'(k * 4 + p);
            drive(1'b0);
        end

        // Single write: bypass same cycle, stored next cycle.
        clr();
        t_we[0] = 1'b1; t_a[0] = 5'd5; t_d[0] = 32'h1234_5678;
        set_ra(5'd5);
        drive(1'b0);
        clr();
        drive(1'b0);

        // Same-address conflict: i2 wins.
        t_we[0] = 1'b1; t_a[0] = 5'd8; t_d[0] = 32'hAAAA_AAAA;
        t_we[1] = 1'b1; t_a[1] = 5'd8; t_d[1] = 32'h5555_5555;
        set_ra(5'd8);
        drive(1'b0);
        clr();
        drive(1'b0);

        // Write to $0 is dropped.
        t_we[0] = 1'b1; t_a[0] = 5'd0; t_d[0] = 32'hFFFF_FFFF;
        set_ra(5'd0);
        drive(1'b0);
        clr();
        drive(1'b0);

        // HI/LO split halves, then HI conflict.
        t_lw[0] = 1'b1; t_l[0] = 32'h11;
        t_hw[1] = 1'b1; t_h[1] = 32'h22;
        drive(1'b0);
        clr();
        t_hw[0] = 1'b1; t_h[0] = 32'h33;
        t_hw[1] = 1'b1; t_h[1] = 32'h44;
        drive(1'b0);
        clr();
        drive(1'b0);

        // Write $3: the non-bypass instance sees it only a cycle later.
        t_we[0] = 1'b1; t_a[0] = 5'd3; t_d[0] = 32'h9;
        set_ra(5'd3);
        drive(1'b0);
        clr();
        drive(1'b0);

        for (int n = 0; n < 400; n++) begin
            rnd();
            drive(1'b0);
        end

        // Populate every GPR and HI/LO, then reset mid-cycle.
        for (int a = 1; a < 32; a += 2) begin
            clr();
            t_we[0] = 1'b1; t_a[0] = 5'(a);     t_d[0] = $urandom;
            t_we[1] = 1'b1; t_a[1] = 5'(a + 1); t_d[1] = $urandom;
            t_hw[0] = 1'b1; t_h[0] = $urandom;
            t_lw[1] = 1'b1; t_l[1] = $urandom;
            for (int p = 0; p < 4; p++) t_ra[p] = 5'($urandom_range(1, 31));
            drive(1'b0);
        end
        rnd();
        drive(1'b1);
        rnd();
        drive(1'b1);

        // First edge after release commits its write.
        clr();
        t_we[0] = 1'b1; t_a[0] = 5'd7; t_d[0] = 32'hCAFE_0007;
        t_lw[1] = 1'b1; t_l[1] = 32'h0BAD_F00D;
        t_ra[0] = 5'd7; t_ra[1] = 5'd9; t_ra[2] = 5'd31; t_ra[3] = 5'd7;
        drive(1'b0);
        clr();
        drive(1'b0);

        for (int n = 0; n < 100; n++) begin
            rnd();
            drive(1'b0);
        end

        @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
